// File: rtl/tt_vector_harness.sv
// Pin-level vector harness for TinyTapeout user designs: resets the DUT, applies a
// table of stimulus vectors and checks the masked responses after a set latency.
module tt_vector_harness #(
    parameter int unsigned IO_W       = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned LAT_W      = 4,
    parameter int unsigned RST_CYCLES = 10,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [$clog2(DEPTH)-1:0]   load_addr,
    input  logic [IO_W-1:0]            load_ui,
    input  logic [IO_W-1:0]            load_uio,
    input  logic [IO_W-1:0]            load_exp,
    input  logic [IO_W-1:0]            load_mask,
    input  logic [$clog2(DEPTH):0]     num_vec,
    input  logic [LAT_W-1:0]           latency,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [CNT_W-1:0]           err_count,
    output logic [$clog2(DEPTH)-1:0]   first_err,
    output logic                       dut_rst_n,
    output logic                       dut_ena,
    output logic [IO_W-1:0]            dut_ui_in,
    output logic [IO_W-1:0]            dut_uio_in,
    input  logic [IO_W-1:0]            dut_uo_out
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned RC_W = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, RESET, APPLY, WAIT, CHECK, DONE} state_t;

    typedef struct packed {
        logic [IO_W-1:0] ui;
        logic [IO_W-1:0] uio;
        logic [IO_W-1:0] expd;
        logic [IO_W-1:0] mask;
    } entry_t;

    entry_t vec_mem [DEPTH];

    state_t            state, state_d;
    logic              busy_d, done_d, pass_d, load_ready_d;
    logic              dut_rst_n_d, dut_ena_d;
    logic [CNT_W-1:0]  err_count_d;
    logic [AW-1:0]     first_err_d;
    logic [IO_W-1:0]   ui_d, uio_d;
    logic [AW:0]       idx, idx_d, num_vec_q, num_vec_d;
    logic [LAT_W-1:0]  lat_m1, lat_m1_d, wait_cnt, wait_cnt_d;
    logic [RC_W-1:0]   rst_cnt, rst_cnt_d;
    entry_t            cur;
    logic              mism_c;

    // Vector table: no reset, writes only while the harness is idle or done
    always_ff @(posedge clk) begin
        if (load_valid && load_ready) begin
            vec_mem[load_addr] <= entry_t'{ui: load_ui, uio: load_uio,
                                           expd: load_exp, mask: load_mask};
        end
    end

    assign cur    = vec_mem[idx[AW-1:0]];
    assign mism_c = |((dut_uo_out ^ cur.expd) & cur.mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            load_ready <= 1'b1;
            err_count  <= '0;
            first_err  <= '0;
            dut_rst_n  <= 1'b0;
            dut_ena    <= 1'b0;
            dut_ui_in  <= '0;
            dut_uio_in <= '0;
            idx        <= '0;
            num_vec_q  <= '0;
            lat_m1     <= '0;
            wait_cnt   <= '0;
            rst_cnt    <= '0;
        end else begin
            state      <= state_d;
            busy       <= busy_d;
            done       <= done_d;
            pass       <= pass_d;
            load_ready <= load_ready_d;
            err_count  <= err_count_d;
            first_err  <= first_err_d;
            dut_rst_n  <= dut_rst_n_d;
            dut_ena    <= dut_ena_d;
            dut_ui_in  <= ui_d;
            dut_uio_in <= uio_d;
            idx        <= idx_d;
            num_vec_q  <= num_vec_d;
            lat_m1     <= lat_m1_d;
            wait_cnt   <= wait_cnt_d;
            rst_cnt    <= rst_cnt_d;
        end
    end

    // Sequencing: APPLY, then L-1 WAIT cycles, then CHECK samples on edge T+L
    always_comb begin
        state_d     = state;
        pass_d      = pass;
        err_count_d = err_count;
        first_err_d = first_err;
        ui_d        = dut_ui_in;
        uio_d       = dut_uio_in;
        idx_d       = idx;
        num_vec_d   = num_vec_q;
        lat_m1_d    = lat_m1;
        wait_cnt_d  = wait_cnt;
        rst_cnt_d   = rst_cnt;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = RESET;
                    num_vec_d   = num_vec;
                    lat_m1_d    = (latency == '0) ? '0 : latency - LAT_W'(1);
                    err_count_d = '0;
                    first_err_d = '0;
                    pass_d      = 1'b1;
                    idx_d       = '0;
                    rst_cnt_d   = RC_W'(RST_CYCLES - 1);
                    ui_d        = '0;
                    uio_d       = '0;
                end
            end
            RESET: begin
                if (rst_cnt == '0) begin
                    state_d = (num_vec_q == '0) ? DONE : APPLY;
                end else begin
                    rst_cnt_d = rst_cnt - RC_W'(1);
                end
            end
            APPLY: begin
                ui_d       = cur.ui;
                uio_d      = cur.uio;
                wait_cnt_d = lat_m1;
                state_d    = (lat_m1 == '0) ? CHECK : WAIT;
            end
            WAIT: begin
                wait_cnt_d = wait_cnt - LAT_W'(1);
                if (wait_cnt == LAT_W'(1)) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (mism_c) begin
                    if (err_count != {CNT_W{1'b1}}) begin
                        err_count_d = err_count + CNT_W'(1);
                    end
                    pass_d = 1'b0;
                    if (pass) begin
                        first_err_d = idx[AW-1:0];
                    end
                end
                idx_d   = idx + (AW+1)'(1);
                state_d = (idx_d == num_vec_q) ? DONE : APPLY;
            end
            default: state_d = IDLE;
        endcase

        busy_d       = (state_d == RESET) || (state_d == APPLY) ||
                       (state_d == WAIT)  || (state_d == CHECK);
        done_d       = (state_d == DONE);
        load_ready_d = (state_d == IDLE) || (state_d == DONE);
        dut_rst_n_d  = (state_d == APPLY) || (state_d == WAIT) ||
                       (state_d == CHECK) || (state_d == DONE);
        dut_ena_d    = (state_d != IDLE);
    end

endmodule
